multicycle_control: RTL

//  Sequencing FSM for the multi-cycle MIPS core variant: one shared memory port, one ALU and IR/MDR/A/B/ALUOut

---
 rtl/multicycle_control_pkg.sv | 68 ++++++
 rtl/multicycle_control.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: state codes, opcodes,
// datapath mux selects and the bundled control word.
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_MEMADR = 4'd2,
        ST_MEMRD  = 4'd3,
        ST_MEMWB  = 4'd4,
        ST_MEMWR  = 4'd5,
        ST_EXEC   = 4'd6,
        ST_ALUWB  = 4'd7,
        ST_BRANCH = 4'd8,
        ST_JUMP   = 4'd9,
        ST_ADDIEX = 4'd10,
        ST_ADDIWB = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
        logic       bus_error;
    } ctrl_t;

    // States that own the shared memory port and run the wait counter
    function automatic logic is_mem_state(input state_e s);
        return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
    endfunction

    function automatic logic op_is_legal(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/multicycle_control.sv
// Sequencing FSM for the multi-cycle MIPS core: drives every datapath mux/enable,
// stretches memory states on mem_ready and aborts stuck accesses after MEM_TIMEOUT.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned TW          = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       illegal_op,
    output logic       bus_error,
    output logic [3:0] state_out
);

    state_e        state_q, state_d;
    logic [TW-1:0] wait_q, wait_d;
    logic          timeout;
    ctrl_t         ctrl;

    // zero only qualifies PCWriteCond inside the datapath's PC enable
    logic unused_zero;
    assign unused_zero = zero;

    assign timeout = is_mem_state(state_q) && !mem_ready && (wait_q == TW'(MEM_TIMEOUT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FETCH;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Next state and wait counter
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            ST_FETCH:  if (mem_ready) state_d = ST_DECODE;
            ST_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_d = ST_EXEC;
                    OP_LW, OP_SW: state_d = ST_MEMADR;
                    OP_BEQ:       state_d = ST_BRANCH;
                    OP_J:         state_d = ST_JUMP;
                    OP_ADDI:      state_d = ST_ADDIEX;
                    default:      state_d = ST_FETCH;
                endcase
            end
            ST_MEMADR: state_d = (opcode == OP_LW) ? ST_MEMRD : ST_MEMWR;
            ST_MEMRD:  if (mem_ready) state_d = ST_MEMWB;
            ST_MEMWB:  state_d = ST_FETCH;
            ST_MEMWR:  if (mem_ready) state_d = ST_FETCH;
            ST_EXEC:   state_d = ST_ALUWB;
            ST_ALUWB:  state_d = ST_FETCH;
            ST_BRANCH: state_d = ST_FETCH;
            ST_JUMP:   state_d = ST_FETCH;
            ST_ADDIEX: state_d = ST_ADDIWB;
            ST_ADDIWB: state_d = ST_FETCH;
            default:   state_d = ST_FETCH;
        endcase
        if (timeout) begin
            state_d = ST_FETCH;
        end
        // Any state entry (including a retried fetch) restarts the count; it saturates otherwise
        if ((state_d != state_q) || timeout) begin
            wait_d = '0;
        end else if (is_mem_state(state_q) && !mem_ready && (wait_q != TW'(MEM_TIMEOUT))) begin
            wait_d = wait_q + TW'(1);
        end
    end

    // Control word decode; IRWrite/PCWrite in FETCH and illegal_op are Mealy
    always_comb begin
        ctrl = '0;
        case (state_q)
            ST_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            ST_DECODE: begin
                ctrl.alu_src_b  = SRCB_IMM_SH2;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.illegal_op = !op_is_legal(opcode);
            end
            ST_MEMADR, ST_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            ST_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            ST_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            ST_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            ST_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            ST_ALUWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_B;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            ST_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            ST_ADDIWB: begin
                ctrl.reg_write = 1'b1;
            end
            default: ;
        endcase
        if (timeout) begin
            ctrl.bus_error = 1'b1;
        end
        // No memory request or register/PC update may leak out while reset is held
        if (rst) begin
            ctrl = '0;
        end
    end

    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign IorD        = ctrl.i_or_d;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign IRWrite     = ctrl.ir_write;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign RegDst      = ctrl.reg_dst;
    assign RegWrite    = ctrl.reg_write;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign ALUOp       = ctrl.alu_op;
    assign PCSource    = ctrl.pc_source;
    assign illegal_op  = ctrl.illegal_op;
    assign bus_error   = ctrl.bus_error;
    assign state_out   = state_q;

endmodule
